// File: rtl/tomasulo_regfile.sv
// Architectural register file with per-register rename status (busy + producer tag)
// for the Tomasulo core. Supplies operands or producer tags at issue, captures CDB
// results, forwards a same-cycle CDB broadcast onto the read ports, and tracks how
// many registers are currently waiting on a producer.
//
// Interface semantics: there is no backpressure. iss_valid and cdb_valid are
// single-cycle strobes sampled on the rising clock edge. No ready signal is
// returned. Read ports are combinational and always valid.
module tomasulo_regfile #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int AW     = $clog2(NREG),
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     rs1_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic              rs1_busy,
    output logic [TAG_W-1:0]  rs1_tag,
    input  logic [AW-1:0]     rs2_addr,
    output logic [DATA_W-1:0] rs2_data,
    output logic              rs2_busy,
    output logic [TAG_W-1:0]  rs2_tag,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_rd,
    input  logic [TAG_W-1:0]  iss_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic              flush,
    output logic [AW:0]       busy_cnt
);

    logic [DATA_W-1:0] regs [NREG];
    logic [TAG_W-1:0]  tags [NREG];
    logic [NREG-1:0]   busy;
    logic [AW:0]       busy_cnt_q;

    logic [NREG-1:0]   cdb_hit;
    logic [NREG-1:0]   iss_hit;
    logic [AW:0]       clr_cnt;
    logic              set_new;
    logic [AW:0]       cnt_next;

    logic [AW-1:0]     rd_addr [2];
    logic [DATA_W-1:0] rd_data [2];
    logic [1:0]        rd_busy;
    logic [TAG_W-1:0]  rd_tag  [2];

    assign rd_addr[0] = rs1_addr;
    assign rd_addr[1] = rs2_addr;

    // Per-register CDB match and issue target; register 0 never matches either.
    // The count delta only removes CDB clears that are not immediately re-set by issue.
    always_comb begin
        cdb_hit = '0;
        iss_hit = '0;
        clr_cnt = '0;
        for (int i = 1; i < NREG; i++) begin
            cdb_hit[i] = busy[i] && cdb_valid && (tags[i] == cdb_tag);
            iss_hit[i] = iss_valid && !flush && (iss_rd == AW'(i));
            if (cdb_hit[i] && !iss_hit[i]) begin
                clr_cnt = clr_cnt + (AW+1)'(1);
            end
        end
        set_new  = iss_valid && !flush && (iss_rd != '0) && !busy[iss_rd];
        cnt_next = busy_cnt_q + {{AW{1'b0}}, set_new} - clr_cnt;
    end

    // State update: CDB writes data, issue renames (wins over CDB clear), flush clears busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
                tags[i] <= '0;
            end
            busy       <= '0;
            busy_cnt_q <= '0;
        end else begin
            busy[0] <= 1'b0;
            for (int i = 1; i < NREG; i++) begin
                if (cdb_hit[i]) begin
                    regs[i] <= cdb_data;
                end
                if (iss_hit[i]) begin
                    tags[i] <= iss_tag;
                end
                if (flush) begin
                    busy[i] <= 1'b0;
                end else if (iss_hit[i]) begin
                    busy[i] <= 1'b1;
                end else if (cdb_hit[i]) begin
                    busy[i] <= 1'b0;
                end
            end
            busy_cnt_q <= flush ? '0 : cnt_next;
        end
    end

    // Combinational operand read with same-cycle CDB forwarding; state is pre-edge.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = regs[rd_addr[p]];
            rd_busy[p] = 1'b0;
            rd_tag[p]  = '0;
            if (rd_addr[p] == '0) begin
                rd_data[p] = '0;
            end else if (busy[rd_addr[p]]) begin
                if (cdb_valid && (tags[rd_addr[p]] == cdb_tag)) begin
                    rd_data[p] = cdb_data;
                end else begin
                    rd_busy[p] = 1'b1;
                    rd_tag[p]  = tags[rd_addr[p]];
                end
            end
        end
    end

    assign rs1_data = rd_data[0];
    assign rs1_busy = rd_busy[0];
    assign rs1_tag  = rd_tag[0];
    assign rs2_data = rd_data[1];
    assign rs2_busy = rd_busy[1];
    assign rs2_tag  = rd_tag[1];
    assign dbg_data = regs[dbg_addr];
    assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_tomasulo_regfile.sv
// Directed bench for tomasulo_regfile. Driver cycles push expected read results into
// exp_q; a monitor at the falling edge pops and compares them, and also checks
// busy_cnt against the population of an independent busy-bit model every cycle.
module tb_tomasulo_regfile;

    localparam int DATA_W = 32;
    localparam int NREG   = 32;
    localparam int AW     = 5;
    localparam int TAG_W  = 4;
    // entry: {port[1:0], data[31:0], busy, tag[3:0], chk_tag, cnt[5:0]}
    localparam int EW     = 2 + DATA_W + 1 + TAG_W + 1 + (AW + 1);

    logic              clk;
    logic              rst_n;
    logic [AW-1:0]     rs1_addr, rs2_addr, dbg_addr;
    logic [DATA_W-1:0] rs1_data, rs2_data, dbg_data;
    logic              rs1_busy, rs2_busy;
    logic [TAG_W-1:0]  rs1_tag, rs2_tag;
    logic              iss_valid;
    logic [AW-1:0]     iss_rd;
    logic [TAG_W-1:0]  iss_tag;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              flush;
    logic [AW:0]       busy_cnt;

    logic [EW-1:0]     exp_q [$];
    string             name_q [$];
    int                checks = 0;
    int                errors = 0;

    logic [NREG-1:0]   mdl_busy = '0;
    logic [TAG_W-1:0]  mdl_tag [NREG];

    tomasulo_regfile #(
        .DATA_W(DATA_W), .NREG(NREG), .TAG_W(TAG_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_addr(rs1_addr), .rs1_data(rs1_data), .rs1_busy(rs1_busy), .rs1_tag(rs1_tag),
        .rs2_addr(rs2_addr), .rs2_data(rs2_data), .rs2_busy(rs2_busy), .rs2_tag(rs2_tag),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_tag(iss_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .flush(flush), .busy_cnt(busy_cnt)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // Independent busy/tag model used for the busy_cnt invariant.
    initial begin
        for (int i = 0; i < NREG; i++) mdl_tag[i] = '0;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_busy = '0;
            for (int i = 0; i < NREG; i++) mdl_tag[i] = '0;
        end else begin
            logic [NREG-1:0] nb;
            nb = mdl_busy;
            for (int i = 1; i < NREG; i++)
                if (mdl_busy[i] && cdb_valid && mdl_tag[i] == cdb_tag) nb[i] = 1'b0;
            if (flush) nb = '0;
            else if (iss_valid && iss_rd != 0) begin
                nb[iss_rd]      = 1'b1;
                mdl_tag[iss_rd] = iss_tag;
            end
            mdl_busy = nb;
        end
    end

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [EW-1:0]     e;
        string             nm;
        logic [1:0]        ep;
        logic [DATA_W-1:0] ed, ad;
        logic              eb, ab, ect;
        logic [TAG_W-1:0]  et, at;
        logic [AW:0]       ec;
        checks++;
        if (busy_cnt !== (AW+1)'($countones(mdl_busy))) begin
            errors++;
            $display("FAIL busy_cnt_invariant t=%0t: got %0d expected %0d",
                     $time, busy_cnt, $countones(mdl_busy));
        end
        while (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            {ep, ed, eb, et, ect, ec} = e;
            case (ep)
                2'd0:    begin ad = rs1_data; ab = rs1_busy; at = rs1_tag; end
                2'd1:    begin ad = rs2_data; ab = rs2_busy; at = rs2_tag; end
                default: begin ad = dbg_data; ab = eb;       at = et;      end
            endcase
            checks++;
            if (ad !== ed) begin
                errors++;
                $display("FAIL %s data: got %h expected %h", nm, ad, ed);
            end
            if (ep != 2'd2) begin
                checks++;
                if (ab !== eb) begin
                    errors++;
                    $display("FAIL %s busy: got %0b expected %0b", nm, ab, eb);
                end
            end
            if (ect) begin
                checks++;
                if (at !== et) begin
                    errors++;
                    $display("FAIL %s tag: got %0d expected %0d", nm, at, et);
                end
            end
            checks++;
            if (busy_cnt !== ec) begin
                errors++;
                $display("FAIL %s busy_cnt: got %0d expected %0d", nm, busy_cnt, ec);
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
        iss_valid = 1'b0;
        iss_rd    = '0;
        iss_tag   = '0;
        cdb_valid = 1'b0;
        cdb_tag   = '0;
        cdb_data  = '0;
        flush     = 1'b0;
    endtask

    task automatic issue(input logic [AW-1:0] rd, input logic [TAG_W-1:0] tg);
        iss_valid = 1'b1;
        iss_rd    = rd;
        iss_tag   = tg;
    endtask

    task automatic bcast(input logic [TAG_W-1:0] tg, input logic [DATA_W-1:0] d);
        cdb_valid = 1'b1;
        cdb_tag   = tg;
        cdb_data  = d;
    endtask

    // port: 0 rs1, 1 rs2, 2 dbg. Checked at the next falling edge.
    task automatic chk(input string nm, input int port, input logic [AW-1:0] a,
                       input logic [DATA_W-1:0] d, input logic b, input logic [TAG_W-1:0] t,
                       input logic ct, input logic [AW:0] c);
        case (port)
            0:       rs1_addr = a;
            1:       rs2_addr = a;
            default: dbg_addr = a;
        endcase
        exp_q.push_back({2'(port), d, b, t, ct, c});
        name_q.push_back(nm);
    endtask

    initial begin
        rst_n = 1'b0;
        rs1_addr = '0; rs2_addr = '0; dbg_addr = '0;
        iss_valid = 1'b0; iss_rd = '0; iss_tag = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; flush = 1'b0;
        tick(); tick();
        rst_n = 1'b1;

        // reset state and r0 issue
        chk("reset_r5", 0, 5, 32'h0, 0, 0, 0, 0);
        issue(0, 3);
        tick();
        chk("r0_after_issue", 0, 0, 32'h0, 0, 0, 1, 0);
        chk("dbg_r0", 2, 0, 32'h0, 0, 0, 0, 0);
        issue(5, 2);
        tick();
        chk("r5_busy", 0, 5, 32'h0, 1, 2, 1, 1);
        chk("r5_busy_rs2", 1, 5, 32'h0, 1, 2, 1, 1);
        tick();
        bcast(2, 32'hDEADBEEF);
        chk("r5_forward", 0, 5, 32'hDEADBEEF, 0, 0, 0, 1);
        tick();
        chk("r5_written", 0, 5, 32'hDEADBEEF, 0, 0, 0, 0);
        chk("dbg_r5", 2, 5, 32'hDEADBEEF, 0, 0, 0, 0);

        // one broadcast, two consumers
        issue(3, 4);
        tick();
        issue(7, 4);
        chk("r3_busy_cnt1", 0, 3, 32'h0, 1, 4, 1, 1);
        tick();
        chk("r3_busy", 0, 3, 32'h0, 1, 4, 1, 2);
        chk("r7_busy", 1, 7, 32'h0, 1, 4, 1, 2);
        tick();
        bcast(4, 32'h55);
        chk("r3_forward", 0, 3, 32'h55, 0, 0, 0, 2);
        chk("r7_forward", 1, 7, 32'h55, 0, 0, 0, 2);
        tick();
        chk("r3_written", 0, 3, 32'h55, 0, 0, 0, 0);
        chk("r7_written", 1, 7, 32'h55, 0, 0, 0, 0);

        // issue overrides same-cycle CDB clear
        issue(9, 1);
        tick();
        bcast(1, 32'hAA);
        issue(9, 6);
        chk("r9_fwd_before_reissue", 0, 9, 32'hAA, 0, 0, 0, 1);
        tick();
        bcast(1, 32'h1234);
        chk("r9_reissued", 0, 9, 32'hAA, 1, 6, 1, 1);
        tick();
        chk("r9_stale_cdb_ignored", 0, 9, 32'hAA, 1, 6, 1, 1);

        // flush with simultaneous issue
        issue(11, 7);
        tick();
        issue(12, 8);
        tick();
        issue(13, 9);
        tick();
        flush = 1'b1;
        issue(10, 2);
        chk("four_busy", 0, 11, 32'h0, 1, 7, 1, 4);
        tick();
        chk("flush_r9", 0, 9, 32'hAA, 0, 0, 0, 0);
        chk("flush_r10", 1, 10, 32'h0, 0, 0, 0, 0);
        chk("flush_dbg_r3", 2, 3, 32'h55, 0, 0, 0, 0);

        // re-issue of a busy register replaces tag, keeps count
        issue(12, 3);
        tick();
        issue(12, 5);
        chk("r12_tag3", 0, 12, 32'h0, 1, 3, 1, 1);
        tick();
        issue(14, 6);
        chk("r12_tag5", 0, 12, 32'h0, 1, 5, 1, 1);
        tick();
        issue(15, 6);
        tick();
        chk("three_busy", 0, 15, 32'h0, 1, 6, 1, 3);

        // asynchronous reset between edges
        tick();
        #2;
        rst_n = 1'b0;
        chk("rst_r5", 0, 5, 32'h0, 0, 0, 1, 0);
        chk("rst_r9", 1, 9, 32'h0, 0, 0, 1, 0);
        chk("rst_dbg_r3", 2, 3, 32'h0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        bcast(6, 32'h77);
        chk("post_rst_r14", 0, 14, 32'h0, 0, 0, 0, 0);
        tick();
        bcast(0, 32'h99);
        chk("post_rst_r14_b", 0, 14, 32'h0, 0, 0, 0, 0);
        chk("post_rst_r15", 1, 15, 32'h0, 0, 0, 0, 0);
        tick();
        chk("post_rst_r15_b", 0, 15, 32'h0, 0, 0, 0, 0);
        chk("post_rst_dbg_r14", 2, 14, 32'h0, 0, 0, 0, 0);
        tick();
        tick();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
